alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted operation runs for one EXEC cycle, then its response is held until the consumer takes it.
module alu_arbiter #(
  parameter logic [31:0] ILLEGAL_RESULT = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [3:0]  req1_ctrl_i,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  output logic        req1_ready_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i,
  output logic [15:0] op_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        id_q;
  logic [3:0]  ctrl_q;
  logic [31:0] src1_q, src2_q;
  logic        rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [31:0] rsp_result_q;
  logic [15:0] op_count_q;

  logic        gnt_valid_s, gnt_id_s;
  logic        accept_s, capture_s, done_s;
  logic        supported_s;

  function automatic logic ctrl_supported(input logic [3:0] ctrl);
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b0111, 4'b1110, 4'b1111: ctrl_supported = 1'b1;
      default:                            ctrl_supported = 1'b0;
    endcase
  endfunction

  // Round-robin pick: a lone requester wins, contention goes to the one not granted last.
  always_comb begin
    gnt_valid_s = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id_s = ~last_grant_q;
    end else if (req1_valid_i) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = gnt_valid_s ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = rsp_ready_i ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: ready only in IDLE, so a response handoff never overlaps a new accept.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    done_s       = 1'b0;
    rsp_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready_o = gnt_valid_s & ~gnt_id_s;
        req1_ready_o = gnt_valid_s & gnt_id_s;
        accept_s     = gnt_valid_s;
      end
      S_EXEC: begin
        capture_s = 1'b1;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        done_s      = rsp_ready_i;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  assign supported_s = ctrl_supported(ctrl_q);

  // Operand latch on accept; these also drive the ALU so it holds its last inputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      ctrl_q       <= 4'd0;
      src1_q       <= 32'd0;
      src2_q       <= 32'd0;
    end else if (accept_s) begin
      last_grant_q <= gnt_id_s;
      id_q         <= gnt_id_s;
      ctrl_q       <= gnt_id_s ? req1_ctrl_i : req0_ctrl_i;
      src1_q       <= gnt_id_s ? req1_src1_i : req0_src1_i;
      src2_q       <= gnt_id_s ? req1_src2_i : req0_src2_i;
    end else begin
      last_grant_q <= last_grant_q;
      id_q         <= id_q;
      ctrl_q       <= ctrl_q;
      src1_q       <= src1_q;
      src2_q       <= src2_q;
    end
  end

  // Response capture at the end of EXEC; unsupported codes are overridden here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (capture_s) begin
      rsp_id_q     <= id_q;
      rsp_result_q <= supported_s ? alu_result_i : ILLEGAL_RESULT;
      rsp_zero_q   <= supported_s ? alu_zero_i : 1'b1;
      rsp_err_q    <= ~supported_s;
    end else begin
      rsp_id_q     <= rsp_id_q;
      rsp_result_q <= rsp_result_q;
      rsp_zero_q   <= rsp_zero_q;
      rsp_err_q    <= rsp_err_q;
    end
  end

  // Completion counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_count_q <= 16'd0;
    end else if (done_s) begin
      op_count_q <= op_count_q + 16'd1;
    end else begin
      op_count_q <= op_count_q;
    end
  end

  assign alu_ctrl_o   = ctrl_q;
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model with per-cycle compare, plus directed literal checks.
module tb_alu_arbiter;

  localparam logic [31:0] ILL = 32'hBAD0_0BAD;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [3:0]  req0_ctrl_i, req1_ctrl_i;
  logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] alu_src1_o, alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o, rsp_id_o, rsp_zero_o, rsp_err_o;
  logic [31:0] rsp_result_o;
  logic        rsp_ready_i;
  logic [15:0] op_count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_arbiter #(.ILLEGAL_RESULT(ILL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ctrl_i(req0_ctrl_i),
    .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_ctrl_i(req1_ctrl_i),
    .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i), .req1_ready_o(req1_ready_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i),
    .op_count_o(op_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU behaviour; unknown codes return junk so the arbiter's override is visible.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0011: alu_fn = a ^ b;
      4'b0100: alu_fn = a << b[4:0];
      4'b0110: alu_fn = a - b;
      4'b0111: alu_fn = {31'd0, $signed(a) < $signed(b)};
      4'b1110: alu_fn = a >> b[4:0];
      4'b1111: alu_fn = $unsigned($signed(a) >>> b[4:0]);
      default: alu_fn = 32'h1234_5678;
    endcase
  endfunction

  assign alu_result_i = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);
  assign alu_zero_i   = (alu_result_i == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: an op is either absent, waiting one cycle in the ALU, or a held response.
  logic        m_inflight, m_holding, m_last, m_id;
  logic [3:0]  m_ctrl;
  logic [31:0] m_a, m_b, m_res;
  logic        m_zero, m_err;
  logic [15:0] m_count;

  function automatic logic legal(input logic [3:0] c);
    legal = c inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_inflight = 1'b0; m_holding = 1'b0; m_last = 1'b1; m_id = 1'b0;
      m_ctrl = 4'd0; m_a = 32'd0; m_b = 32'd0; m_count = 16'd0;
    end else if (m_holding) begin
      if (rsp_ready_i) begin
        m_holding = 1'b0;
        m_count = m_count + 16'd1;
      end
    end else if (m_inflight) begin
      m_inflight = 1'b0;
      m_holding  = 1'b1;
      m_err  = !legal(m_ctrl);
      m_res  = m_err ? ILL : alu_fn(m_ctrl, m_a, m_b);
      m_zero = m_err ? 1'b1 : (m_res == 32'd0);
    end else if (req0_valid_i || req1_valid_i) begin
      m_id = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
      m_last = m_id;
      m_inflight = 1'b1;
      m_ctrl = m_id ? req1_ctrl_i : req0_ctrl_i;
      m_a    = m_id ? req1_src1_i : req0_src1_i;
      m_b    = m_id ? req1_src2_i : req0_src2_i;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    logic idle, e0, e1;
    if (rst_i) begin
      chk("rst_valid", rsp_valid_o, 0); chk("rst_id", rsp_id_o, 0);
      chk("rst_err", rsp_err_o, 0);     chk("rst_zero", rsp_zero_o, 0);
      chk("rst_result", rsp_result_o, 0); chk("rst_count", op_count_o, 0);
      chk("rst_alu_a", alu_src1_o, 0);  chk("rst_alu_b", alu_src2_o, 0);
      chk("rst_alu_c", alu_ctrl_o, 0);
    end else begin
      idle = !m_inflight && !m_holding;
      e0 = idle && req0_valid_i && (!req1_valid_i || m_last);
      e1 = idle && req1_valid_i && (!req0_valid_i || !m_last);
      chk("ready0", req0_ready_o, e0);
      chk("ready1", req1_ready_o, e1);
      chk("rsp_valid", rsp_valid_o, m_holding);
      chk("count", op_count_o, m_count);
      chk("alu_ctrl", alu_ctrl_o, m_ctrl);
      chk("alu_a", alu_src1_o, m_a);
      chk("alu_b", alu_src2_o, m_b);
      if (m_holding) begin
        chk("rsp_result", rsp_result_o, m_res);
        chk("rsp_zero", rsp_zero_o, m_zero);
        chk("rsp_err", rsp_err_o, m_err);
        chk("rsp_id", rsp_id_o, m_id);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
  task automatic send(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    if (id) begin
      req1_valid_i = 1'b1; req1_ctrl_i = c; req1_src1_i = a; req1_src2_i = b;
    end else begin
      req0_valid_i = 1'b1; req0_ctrl_i = c; req0_src1_i = a; req0_src2_i = b;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      got = id ? req1_ready_o : req0_ready_o;
      if (got) break;
    end
    chk("send_handshake", got, 1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin got = 1'b1; break; end
    end
    chk("rsp_wait", got, 1);
  endtask

  logic [3:0] codes [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
  logic       ids [4];

  initial begin
    rst_i = 1'b1; rsp_ready_i = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_ctrl_i = 4'd0; req1_ctrl_i = 4'd0;
    req0_src1_i = 32'd0; req0_src2_i = 32'd0; req1_src1_i = 32'd0; req1_src2_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Single request: 5 + 7, response visible two cycles after the handshake cycle.
    rsp_ready_i = 1'b1;
    send(1'b0, 4'b0010, 32'd5, 32'd7);
    @(negedge clk_i); chk("lat_exec_valid", rsp_valid_o, 0);
    @(negedge clk_i); chk("lat_resp_valid", rsp_valid_o, 1);
    chk("add_result", rsp_result_o, 32'd12); chk("add_zero", rsp_zero_o, 0);
    chk("add_id", rsp_id_o, 0);
    @(negedge clk_i); chk("add_count", op_count_o, 16'd1);
    @(posedge clk_i); #1;

    // Round-robin from reset: both valid continuously.
    rst_i = 1'b1; @(posedge clk_i); #1 rst_i = 1'b0;
    req0_ctrl_i = 4'b0000; req0_src1_i = 32'hF0F0_F0F0; req0_src2_i = 32'h0FF0_0FF0;
    req1_ctrl_i = 4'b0001; req1_src1_i = 32'h0000_00A0; req1_src2_i = 32'h0000_000B;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    begin
      int n;
      n = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
        @(negedge clk_i);
        if (rsp_valid_o) begin ids[n] = rsp_id_o; n++; end
      end
      chk("rr_count_seen", n, 4);
    end
    chk("rr_id0", ids[0], 0); chk("rr_id1", ids[1], 1);
    chk("rr_id2", ids[2], 0); chk("rr_id3", ids[3], 1);
    @(posedge clk_i); #1 req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    repeat (6) @(posedge clk_i); #1;

    // Held response with back-pressure: 9 - 9.
    rsp_ready_i = 1'b0;
    send(1'b1, 4'b0110, 32'd9, 32'd9);
    wait_rsp();
    chk("sub_id", rsp_id_o, 1);
    repeat (5) begin
      @(negedge clk_i);
      chk("hold_valid", rsp_valid_o, 1); chk("hold_result", rsp_result_o, 32'd0);
      chk("hold_zero", rsp_zero_o, 1);
    end
    @(posedge clk_i); #1 rsp_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); chk("release_valid", rsp_valid_o, 0);
    @(posedge clk_i); #1;

    // Unsupported control code.
    send(1'b0, 4'b0101, 32'd3, 32'd4);
    wait_rsp();
    chk("ill_result", rsp_result_o, ILL); chk("ill_err", rsp_err_o, 1);
    chk("ill_zero", rsp_zero_o, 1);
    @(posedge clk_i); #1;

    // Sweep of every supported code.
    for (int i = 0; i < 9; i++) begin
      send(i[0], codes[i], 32'h8000_00F3, 32'h0000_0004);
      wait_rsp();
      chk("sweep_err", rsp_err_o, 0);
      @(posedge clk_i); #1;
    end

    // Reset during EXEC discards the operation; req0 wins the next contention.
    send(1'b1, 4'b0010, 32'd1, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_valid", rsp_valid_o, 0); chk("abort_count", op_count_o, 0);
    chk("abort_alu_a", alu_src1_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    @(negedge clk_i); chk("post_rst_gnt0", req0_ready_o, 1); chk("post_rst_gnt1", req1_ready_o, 0);
    @(posedge clk_i); #1 req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    repeat (5) @(posedge clk_i); #1;

    // Counter wrap from 16'hFFFF.
    force dut.op_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge clk_i); release dut.op_count_q;
    @(posedge clk_i); #1;
    send(1'b0, 4'b0011, 32'h55, 32'hAA);
    wait_rsp();
    chk("pre_wrap_count", op_count_o, 16'hFFFF);
    @(posedge clk_i); @(negedge clk_i); chk("wrap_count", op_count_o, 16'd0);

    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
